// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encoding and mode helpers.
package shifter_pkg;

  typedef enum logic [2:0] {
    MODE_SRL = 3'b000,
    MODE_SLL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ROL = 3'b100
  } shift_mode_e;

  // Codes 101..111 are reserved: data passes through unshifted and is flagged.
  function automatic logic is_reserved(input logic [2:0] mode);
    return mode > MODE_ROL;
  endfunction

  // Left modes are built from the right-shift core by reversing bits on entry and exit.
  function automatic logic is_left(input logic [2:0] mode);
    return (mode == MODE_SLL) || (mode == MODE_ROL);
  endfunction

  function automatic logic is_rot(input logic [2:0] mode);
    return (mode == MODE_ROR) || (mode == MODE_ROL);
  endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// One register stage of the shifter: applies a contiguous range of shift levels
// (each level k shifts right by 2^k) and holds the beat with its valid/ready slice.
module shifter_pipe_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LO_LEVEL = 0,
  parameter int HI_LEVEL = 0,
  parameter int AW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amount,
  input  logic [2:0]       in_mode,
  input  logic             in_fill,
  input  logic             in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_amount,
  output logic [2:0]       out_mode,
  output logic             out_fill,
  output logic             out_err
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [AW-1:0]    r_amount;
  logic [2:0]       r_mode;
  logic             r_fill;
  logic             r_err;
  logic [WIDTH-1:0] w_shifted;

  // The stage can take a new beat when it is empty or its current beat leaves this cycle.
  assign in_ready = !r_valid || out_ready;

  // Apply this stage's shift levels; reserved-mode beats pass through untouched.
  always_comb begin
    w_shifted = in_data;
    for (int k = LO_LEVEL; k <= HI_LEVEL; k++) begin
      if (in_amount[k] && !in_err) begin
        if (is_rot(in_mode)) begin
          w_shifted = (w_shifted >> (1 << k)) | (w_shifted << (WIDTH - (1 << k)));
        end else begin
          w_shifted = (w_shifted >> (1 << k)) | (in_fill ? ~(ONES >> (1 << k)) : '0);
        end
      end
    end
  end

  // Stage register: load on accept, otherwise hold the beat stable for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_amount <= '0;
      r_mode   <= 3'b000;
      r_fill   <= 1'b0;
      r_err    <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data   <= w_shifted;
        r_amount <= in_amount;
        r_mode   <= in_mode;
        r_fill   <= in_fill;
        r_err    <= in_err;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_amount = r_amount;
  assign out_mode   = r_mode;
  assign out_fill   = r_fill;
  assign out_err    = r_err;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshake and full backpressure.
// Entry reversal turns left modes into right shifts; exit reversal restores the order.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int  WIDTH  = 32,
  parameter int  STAGES = 2,
  localparam int AW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amount,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [STAGES:0]            w_valid;
  logic [STAGES:0]            w_ready;
  logic [STAGES:0]            w_fill;
  logic [STAGES:0]            w_err;
  logic [STAGES:0][WIDTH-1:0] w_data;
  logic [STAGES:0][AW-1:0]    w_amount;
  logic [STAGES:0][2:0]       w_mode;
  logic [AW:0]                w_unusedTail;

  function automatic logic [WIDTH-1:0] bitRev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = d[WIDTH-1-i];
    end
    return r;
  endfunction

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = is_left(in_mode) ? bitRev(in_data) : in_data;
  assign w_amount[0]     = in_amount;
  assign w_mode[0]       = in_mode;
  assign w_fill[0]       = (in_mode == MODE_SRA) && in_data[WIDTH-1];
  assign w_err[0]        = is_reserved(in_mode);
  assign in_ready        = w_ready[0];
  assign w_ready[STAGES] = out_ready;

  // Level k lives in stage floor(k*STAGES/LEVELS), giving each stage a contiguous range.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = (s * LEVELS + STAGES - 1) / STAGES;
    localparam int HI = ((s + 1) * LEVELS + STAGES - 1) / STAGES - 1;

    shifter_pipe_stage #(
      .WIDTH    (WIDTH),
      .LO_LEVEL (LO),
      .HI_LEVEL (HI),
      .AW       (AW)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (w_valid[s]),
      .in_ready   (w_ready[s]),
      .in_data    (w_data[s]),
      .in_amount  (w_amount[s]),
      .in_mode    (w_mode[s]),
      .in_fill    (w_fill[s]),
      .in_err     (w_err[s]),
      .out_valid  (w_valid[s+1]),
      .out_ready  (w_ready[s+1]),
      .out_data   (w_data[s+1]),
      .out_amount (w_amount[s+1]),
      .out_mode   (w_mode[s+1]),
      .out_fill   (w_fill[s+1]),
      .out_err    (w_err[s+1])
    );
  end

  assign out_valid    = w_valid[STAGES];
  assign out_data     = is_left(w_mode[STAGES]) ? bitRev(w_data[STAGES]) : w_data[STAGES];
  assign out_err      = w_err[STAGES];
  assign w_unusedTail = {w_fill[STAGES], w_amount[STAGES]};

endmodule
